// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 16;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} arb_state_t;

  function automatic arb_state_t own_state(input logic m);
    return m ? OWN1 : OWN0;
  endfunction

  function automatic logic [1:0] gnt_of(input logic m);
    return m ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner select between two requesters (0 = m0, 1 = m1).
module wb_arb_pick #(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

  always_comb begin
    win = 1'b0;
    // On a tie round-robin favours whoever did not own the bus last
    if (req == 2'b11) win = RR ? ~last : 1'b0;
    else              win = req[1];
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter: per-cycle grant, outstanding-strobe
// tracking, owner-only ack/data return and optional forced handover.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int RR       = 1,
  parameter int MAX_OUT  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_wdat,
  output logic [DAT_W-1:0] m0_rdat,
  output logic             m0_ack,
  output logic             m0_stall,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_wdat,
  output logic [DAT_W-1:0] m1_rdat,
  output logic             m1_ack,
  output logic             m1_stall,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_wdat,
  input  logic [DAT_W-1:0] s_rdat,
  input  logic             s_ack,
  input  logic             s_stall,
  output logic [1:0]       gnt
);

  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  arb_state_t        state_reg;
  logic              owner_reg;
  logic              last_reg;
  logic [OUT_W-1:0]  out_cnt_reg, out_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [1:0]        gnt_reg;

  logic             win;
  logic             sel_cyc, sel_stb, sel_we, other_cyc;
  logic [ADR_W-1:0] sel_adr;
  logic [DAT_W-1:0] sel_wdat;
  logic             out_full, hold_block, accepted, ack_ok, own_stall;

  wb_arb_pick #(.RR(RR != 0)) u_pick (
    .req  ({m1_cyc, m0_cyc}),
    .last (last_reg),
    .win  (win)
  );

  assign sel_cyc   = owner_reg ? m1_cyc  : m0_cyc;
  assign sel_stb   = owner_reg ? m1_stb  : m0_stb;
  assign sel_we    = owner_reg ? m1_we   : m0_we;
  assign sel_adr   = owner_reg ? m1_adr  : m0_adr;
  assign sel_wdat  = owner_reg ? m1_wdat : m0_wdat;
  assign other_cyc = owner_reg ? m0_cyc  : m1_cyc;

  assign out_full   = (out_cnt_reg == OUT_MAX);
  // Once the hold budget is spent and the other side waits, stop issuing new strobes
  assign hold_block = HOLD_EN && (hold_cnt_reg == HOLD_MAX) && other_cyc;
  assign accepted   = s_stb && !s_stall;
  assign ack_ok     = s_ack && (out_cnt_reg != '0) && (state_reg != IDLE);
  assign gnt        = gnt_reg;

  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_wdat    = '0;
    own_stall = 1'b1;
    case (state_reg)
      OWN0, OWN1: begin
        s_cyc     = sel_cyc;
        s_stb     = sel_cyc && sel_stb && !out_full && !hold_block;
        s_we      = sel_we;
        s_adr     = sel_adr;
        s_wdat    = sel_wdat;
        own_stall = s_stall || out_full || hold_block;
      end
      DRAIN: s_cyc = sel_cyc && (out_cnt_reg != '0);
      default: ;
    endcase
  end

  always_comb begin
    m0_stall = m0_cyc;
    m1_stall = m1_cyc;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rdat  = '0;
    m1_rdat  = '0;
    if (state_reg != IDLE) begin
      if (owner_reg) begin
        m1_stall = own_stall;
        m1_ack   = ack_ok;
        m1_rdat  = s_rdat;
        m0_stall = 1'b1;
      end else begin
        m0_stall = own_stall;
        m0_ack   = ack_ok;
        m0_rdat  = s_rdat;
        m1_stall = 1'b1;
      end
    end
  end

  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (accepted && !ack_ok)      out_cnt_next = out_cnt_reg + OUT_W'(1);
    else if (!accepted && ack_ok) out_cnt_next = out_cnt_reg - OUT_W'(1);
    hold_cnt_next = hold_cnt_reg;
    if (HOLD_EN && accepted && (hold_cnt_reg != HOLD_MAX))
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      out_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      gnt_reg      <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_cyc || m1_cyc) begin
            owner_reg <= win;
            state_reg <= own_state(win);
            gnt_reg   <= gnt_of(win);
          end
        end
        default: begin
          // A finished drain ends the tenure exactly like the owner dropping cyc
          if (!sel_cyc || (state_reg == DRAIN && out_cnt_reg == '0)) begin
            out_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            last_reg     <= owner_reg;
            if (other_cyc) begin
              owner_reg <= ~owner_reg;
              state_reg <= own_state(~owner_reg);
              gnt_reg   <= gnt_of(~owner_reg);
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 2'b00;
            end
          end else begin
            out_cnt_reg  <= out_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            if (state_reg != DRAIN && HOLD_EN && hold_cnt_next == HOLD_MAX && other_cyc)
              state_reg <= DRAIN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench: instance a (RR=1, MAX_OUT=4, MAX_HOLD=16), instance b (RR=0, MAX_HOLD=0).
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [15:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [15:0] s_rdat;
  logic        s_ack, s_stall;

  logic [15:0] m0_rdat, m1_rdat, s_adr, s_wdat;
  logic        m0_ack, m1_ack, m0_stall, m1_stall, s_cyc, s_stb, s_we;
  logic [1:0]  gnt;

  logic [15:0] b_m0_rdat, b_m1_rdat, b_s_adr, b_s_wdat;
  logic        b_m0_ack, b_m1_ack, b_m0_stall, b_m1_stall, b_s_cyc, b_s_stb, b_s_we;
  logic [1:0]  b_gnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt;
  logic acc, acc_prev;

  always #5 clk = ~clk;

  wb_arbiter2 #(.RR(1), .MAX_OUT(4), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdat(m0_wdat),
    .m0_rdat(m0_rdat), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdat(m1_wdat),
    .m1_rdat(m1_rdat), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_wdat(s_wdat),
    .s_rdat(s_rdat), .s_ack(s_ack), .s_stall(s_stall), .gnt(gnt)
  );

  wb_arbiter2 #(.RR(0), .MAX_OUT(4), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdat(m0_wdat),
    .m0_rdat(b_m0_rdat), .m0_ack(b_m0_ack), .m0_stall(b_m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdat(m1_wdat),
    .m1_rdat(b_m1_rdat), .m1_ack(b_m1_ack), .m1_stall(b_m1_stall),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr), .s_wdat(b_s_wdat),
    .s_rdat(s_rdat), .s_ack(s_ack), .s_stall(s_stall), .gnt(b_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdat = '0;
    s_rdat = '0; s_ack = 1'b0; s_stall = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    #2;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m0_stall", m0_stall, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    $display("[TB] reset checked");

    // 1: m0 single read
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0010; m0_we = 1'b0;
    #2;
    chk("t1_stall_pre", m0_stall, 1'b1);
    chk("t1_gnt_pre", gnt, 2'b00);
    tick();
    #2;
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_s_stb", s_stb, 1'b1);
    chk("t1_s_adr", s_adr, 16'h0010);
    chk("t1_m0_stall", m0_stall, 1'b0);
    tick();
    m0_stb = 1'b0; s_ack = 1'b1; s_rdat = 16'h1234;
    #2;
    chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m0_rdat", m0_rdat, 16'h1234);
    chk("t1_m1_ack", m1_ack, 1'b0);
    chk("t1_m1_rdat", m1_rdat, 16'h0000);
    $display("[TB] t1 m0 read 0x0010 -> 0x%04h", m0_rdat);
    tick();
    s_ack = 1'b0; s_rdat = '0; m0_cyc = 1'b0;
    #2;
    chk("t1_s_cyc_end", s_cyc, 1'b0);
    tick();
    chk("t1_gnt_idle", gnt, 2'b00);

    // 2: simultaneous requests, round-robin handover
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    #2;
    chk("t2_gnt_first", gnt, 2'b01);
    chk("t2_b_gnt_first", b_gnt, 2'b01);
    chk("t2_m1_stall", m1_stall, 1'b1);
    tick();
    m0_cyc = 1'b0;
    #2;
    chk("t2_s_cyc_drop", s_cyc, 1'b0);
    tick();
    chk("t2_gnt_m1", gnt, 2'b10);
    m1_cyc = 1'b0;
    tick();
    chk("t2_gnt_idle", gnt, 2'b00);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("t2_gnt_tie2", gnt, 2'b01);
    chk("t2_b_gnt_tie2", b_gnt, 2'b01);
    $display("[TB] t2 round-robin sequence done");
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();

    // 3: outstanding limit with a silent slave
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (m0_stb && !m0_stall) cnt++;
      tick();
    end
    #2;
    chk("t3_accepts", cnt, 4);
    chk("t3_m0_stall", m0_stall, 1'b1);
    chk("t3_s_stb_full", s_stb, 1'b0);
    s_ack = 1'b1;
    #1;
    chk("t3_m0_ack", m0_ack, 1'b1);
    tick();
    s_ack = 1'b0;
    #2;
    chk("t3_s_stb_freed", s_stb, 1'b1);
    chk("t3_stall_freed", m0_stall, 1'b0);
    tick();
    #2;
    chk("t3_s_stb_refull", s_stb, 1'b0);
    $display("[TB] t3 accepted %0d strobes before stall", cnt);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();

    // 4: forced handover after the hold budget
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1;
    acc_prev = 1'b0; cnt = 0;
    for (int i = 0; i < 60 && cnt < 16; i++) begin
      s_ack = acc_prev;
      #2;
      acc = s_stb && !s_stall;
      if (acc) cnt++;
      acc_prev = acc;
      tick();
    end
    chk("t4_accepts", cnt, 16);
    s_ack = acc_prev;
    #2;
    chk("t4_drain_stb", s_stb, 1'b0);
    chk("t4_drain_cyc", s_cyc, 1'b1);
    chk("t4_drain_stall", m0_stall, 1'b1);
    chk("t4_drain_gnt", gnt, 2'b01);
    chk("t4_drain_ack", m0_ack, 1'b1);
    tick();
    s_ack = 1'b0;
    #2;
    chk("t4_gap_cyc", s_cyc, 1'b0);
    chk("t4_gap_gnt", gnt, 2'b01);
    tick();
    #2;
    chk("t4_gnt_m1", gnt, 2'b10);
    chk("t4_m1_cyc", s_cyc, 1'b1);
    chk("t4_m0_wait", m0_stall, 1'b1);
    $display("[TB] t4 drain after %0d accepts, gnt=%b", cnt, gnt);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0;
    tick();

    // 5: reset with three reads in flight
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick(); tick(); tick(); tick();
    m0_stb = 1'b0; rst = 1'b1;
    #2;
    chk("t5_gnt_pre", gnt, 2'b01);
    tick();
    rst = 1'b0; s_ack = 1'b1;
    #2;
    chk("t5_gnt_rst", gnt, 2'b00);
    chk("t5_s_cyc_rst", s_cyc, 1'b0);
    chk("t5_m0_ack_rst", m0_ack, 1'b0);
    chk("t5_m1_ack_rst", m1_ack, 1'b0);
    tick();
    #2;
    chk("t5_gnt_regrant", gnt, 2'b01);
    chk("t5_late_ack", m0_ack, 1'b0);
    $display("[TB] t5 late ack after reset dropped");
    s_ack = 1'b0; m0_cyc = 1'b0;
    tick();

    // 6: fixed priority, no hold limit: m1 keeps the bus until it lets go
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    m0_cyc = 1'b1; acc_prev = 1'b0; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      s_ack = acc_prev;
      #2;
      acc = b_s_stb && !s_stall;
      if (acc) cnt++;
      acc_prev = acc;
      tick();
    end
    #2;
    chk("t6_accepts", cnt, 20);
    chk("t6_b_gnt_m1", b_gnt, 2'b10);
    chk("t6_b_m0_stall", b_m0_stall, 1'b1);
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    #1;
    chk("t6_b_s_cyc_drop", b_s_cyc, 1'b0);
    tick();
    #2;
    chk("t6_b_gnt_m0", b_gnt, 2'b01);
    chk("t6_b_s_cyc_m0", b_s_cyc, 1'b1);
    $display("[TB] t6 m1 held %0d strobes, then gnt=%b", cnt, b_gnt);
    m0_cyc = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
